// File: rtl/fir_controller.sv
// Sequencer for a time-multiplexed FIR datapath: one multiply-accumulate per tap,
// with the accumulate enable delayed to line up with the datapath product pipeline.
module fir_controller #(
  parameter int unsigned TAPS     = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_valid,
  output logic              ready,
  output logic [ADDR_W-1:0] address,
  output logic              newInput,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              output_valid,
  output logic              overrun
);

  localparam int unsigned     CNT_W      = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MAC,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    drain_cnt;
  logic [PIPE_LAT-1:0] en_pipe;
  logic                mac_active;

  // Sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      address      <= '0;
      ready        <= 1'b1;
      newInput     <= 1'b0;
      acc_clr      <= 1'b0;
      output_valid <= 1'b0;
      overrun      <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      if (input_valid && !ready) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (input_valid) begin
            state    <= SHIFT;
            ready    <= 1'b0;
            newInput <= 1'b1;
            acc_clr  <= 1'b1;
            address  <= '0;
          end
        end
        SHIFT: begin
          state    <= MAC;
          newInput <= 1'b0;
          acc_clr  <= 1'b0;
          address  <= '0;
        end
        MAC: begin
          if (address == LAST_ADDR) begin
            state     <= DRAIN;
            address   <= '0;
            drain_cnt <= '0;
          end else begin
            address <= address + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Hold long enough for the last product to reach the accumulator.
          if (drain_cnt == LAST_DRAIN) begin
            state        <= DONE;
            output_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state        <= IDLE;
          output_valid <= 1'b0;
          ready        <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          ready        <= 1'b1;
          address      <= '0;
          newInput     <= 1'b0;
          acc_clr      <= 1'b0;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mac_active = (state == MAC);

  // Accumulate enable trails the MAC window by the product pipeline depth.
  if (PIPE_LAT == 1) begin : g_en_pipe_1
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_pipe <= '0;
      end else begin
        en_pipe <= mac_active;
      end
    end
  end else begin : g_en_pipe_n
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_pipe <= '0;
      end else begin
        en_pipe <= {en_pipe[PIPE_LAT-2:0], mac_active};
      end
    end
  end

  assign acc_en = en_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_fir_controller.sv
// Bench for fir_controller: timeline model per sample, event logs with literal
// timing checks, and an impulse run through a behavioural datapath.
module tb_fir_controller;

  localparam int TAPS0 = 64;
  localparam int PL0   = 2;
  localparam int TAPS1 = 4;
  localparam int PL1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv0, iv1;
  logic       rdy0, ni0, clr0, en0, ov0, or0;
  logic [5:0] a0;
  logic       rdy1, ni1, clr1, en1, ov1, or1;
  logic [1:0] a1;

  fir_controller #(.TAPS(TAPS0), .ADDR_W(6), .PIPE_LAT(PL0)) u_dut0 (
    .clk(clk), .rst(rst), .input_valid(iv0), .ready(rdy0), .address(a0),
    .newInput(ni0), .acc_clr(clr0), .acc_en(en0), .output_valid(ov0), .overrun(or0)
  );

  fir_controller #(.TAPS(TAPS1), .ADDR_W(2), .PIPE_LAT(PL1)) u_dut1 (
    .clk(clk), .rst(rst), .input_valid(iv1), .ready(rdy1), .address(a1),
    .newInput(ni1), .acc_clr(clr1), .acc_en(en1), .output_valid(ov1), .overrun(or1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: rel = cycles since the accepting edge, 0 when idle.
  typedef struct packed {
    logic       ready;
    logic [5:0] address;
    logic       ni;
    logic       clr;
    logic       en;
    logic       ov;
    logic       orun;
  } obs_t;

  function automatic obs_t expect_out(input int taps, input int pl, input int rel, input logic orun);
    obs_t e;
    e.ready   = (rel == 0);
    e.address = (rel >= 2 && rel <= taps + 1) ? 6'(rel - 2) : 6'd0;
    e.ni      = (rel == 1);
    e.clr     = (rel == 1);
    e.en      = (rel >= pl + 2 && rel <= taps + pl + 1);
    e.ov      = (rel == taps + pl + 2);
    e.orun    = orun;
    return e;
  endfunction

  int   rel0 = 0, rel1 = 0;
  logic orun0 = 1'b0, orun1 = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel0 <= 0; orun0 <= 1'b0;
      rel1 <= 0; orun1 <= 1'b0;
    end else begin
      if (rel0 == 0) begin
        if (iv0) rel0 <= 1;
      end else begin
        if (iv0) orun0 <= 1'b1;
        rel0 <= (rel0 == TAPS0 + PL0 + 2) ? 0 : rel0 + 1;
      end
      if (rel1 == 0) begin
        if (iv1) rel1 <= 1;
      end else begin
        if (iv1) orun1 <= 1'b1;
        rel1 <= (rel1 == TAPS1 + PL1 + 2) ? 0 : rel1 + 1;
      end
    end
  end

  // Behavioural datapath: all-ones coefficients, PIPE_LAT-deep product pipe.
  logic [15:0] din;
  logic [15:0] din_q;
  logic [15:0] sr   [0:63];
  logic [15:0] coef [0:63];
  logic [31:0] pp0, pp1, acc;

  initial for (int i = 0; i < 64; i++) coef[i] = 16'd1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= '0;
      for (int i = 0; i < 64; i++) sr[i] <= '0;
      pp0 <= '0; pp1 <= '0; acc <= '0;
    end else begin
      if (iv0 && rdy0) din_q <= din;
      if (ni0) begin
        for (int i = 63; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= din_q;
      end
      pp0 <= 32'(sr[a0]) * 32'(coef[a0]);
      pp1 <= pp0;
      if (clr0) acc <= '0;
      else if (en0) acc <= acc + pp1;
    end
  end

  // Event log, indexed by cycle number after the accepting edge.
  int ecnt = 0;
  int e0   = 0;
  logic log_on = 1'b0;
  int lg [0:1][0:5][0:511];

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (log_on && (ecnt - e0 + 1) >= 0 && (ecnt - e0 + 1) < 512) begin
      lg[0][0][ecnt-e0+1] <= int'(ni0);
      lg[0][1][ecnt-e0+1] <= int'(clr0);
      lg[0][2][ecnt-e0+1] <= int'(en0);
      lg[0][3][ecnt-e0+1] <= int'(ov0);
      lg[0][4][ecnt-e0+1] <= int'(or0);
      lg[0][5][ecnt-e0+1] <= int'(a0);
      lg[1][0][ecnt-e0+1] <= int'(ni1);
      lg[1][1][ecnt-e0+1] <= int'(clr1);
      lg[1][2][ecnt-e0+1] <= int'(en1);
      lg[1][3][ecnt-e0+1] <= int'(ov1);
      lg[1][4][ecnt-e0+1] <= int'(or1);
      lg[1][5][ecnt-e0+1] <= int'(a1);
    end
  end

  task automatic clear_log();
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 6; s++)
        for (int c = 0; c < 512; c++) lg[i][s][c] = 0;
  endtask

  function automatic int cnt(input int inst, input int sel, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (lg[inst][sel][c] != 0) n++;
    return n;
  endfunction

  function automatic int first_from(input int inst, input int sel, input int lo);
    for (int c = lo; c < 512; c++) if (lg[inst][sel][c] != 0) return c;
    return -1;
  endfunction

  function automatic int last_of(input int inst, input int sel);
    for (int c = 511; c >= 0; c--) if (lg[inst][sel][c] != 0) return c;
    return -1;
  endfunction

  // Per-cycle compare against the model, plus datapath result on each strobe.
  logic chk_on = 1'b0;
  logic dp_on  = 1'b0;
  int   out_idx = 0;
  obs_t act0, act1, exp0, exp1;

  always @(negedge clk) begin
    if (chk_on) begin
      act0 = {rdy0, a0, ni0, clr0, en0, ov0, or0};
      act1 = {rdy1, 4'b0000, a1, ni1, clr1, en1, ov1, or1};
      exp0 = expect_out(TAPS0, PL0, rel0, orun0);
      exp1 = expect_out(TAPS1, PL1, rel1, orun1);
      total++;
      if (act0 !== exp0) begin
        bad++;
        $display("FAIL model64 t=%0t got %h want %h", $time, act0, exp0);
      end
      total++;
      if (act1 !== exp1) begin
        bad++;
        $display("FAIL model4 t=%0t got %h want %h", $time, act1, exp1);
      end
    end
    if (dp_on && ov0) begin
      check("e2e_dout", int'(acc), (out_idx < 64) ? 1 : 0);
      out_idx++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0; din = '0;
    repeat (3) step();
    chk_on = 1'b1;
    step();
    check("rst_ready", int'(rdy0), 1);
    check("rst_addr", int'(a0), 0);
    check("rst_overrun", int'(or0), 0);
    check("rst_valid", int'(ov0), 0);
    check("rst_ready_small", int'(rdy1), 1);
    rst = 1'b1;
    repeat (2) step();

    // Single sample on both configurations.
    clear_log();
    iv0 = 1'b1; iv1 = 1'b1;
    step(); e0 = ecnt; log_on = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0;
    repeat (80) step();
    log_on = 1'b0;
    check("single_ni_first", first_from(0, 0, 0), 1);
    check("single_ni_count", cnt(0, 0, 0, 511), 1);
    check("single_clr_count", cnt(0, 1, 0, 511), 1);
    check("single_addr_c2", lg[0][5][2], 0);
    check("single_addr_c3", lg[0][5][3], 1);
    check("single_addr_c65", lg[0][5][65], 63);
    check("single_addr_c66", lg[0][5][66], 0);
    check("single_en_first", first_from(0, 2, 0), 4);
    check("single_en_last", last_of(0, 2), 67);
    check("single_en_count", cnt(0, 2, 0, 511), 64);
    check("single_ov_cycle", first_from(0, 3, 0), 68);
    check("single_ov_count", cnt(0, 3, 0, 511), 1);
    check("small_addr_c2", lg[1][5][2], 0);
    check("small_addr_c5", lg[1][5][5], 3);
    check("small_addr_c6", lg[1][5][6], 0);
    check("small_en_first", first_from(1, 2, 0), 3);
    check("small_en_last", last_of(1, 2), 6);
    check("small_ov_cycle", first_from(1, 3, 0), 7);
    check("small_ov_count", cnt(1, 3, 0, 511), 1);

    // Busy input at cycle 30.
    clear_log();
    iv0 = 1'b1;
    step(); e0 = ecnt; log_on = 1'b1;
    iv0 = 1'b0;
    repeat (29) step();
    iv0 = 1'b1;
    step();
    iv0 = 1'b0;
    repeat (50) step();
    log_on = 1'b0;
    check("busy_overrun_first", first_from(0, 4, 0), 31);
    check("busy_ni_count", cnt(0, 0, 0, 511), 1);
    check("busy_ov_cycle", first_from(0, 3, 0), 68);
    check("busy_ov_count", cnt(0, 3, 0, 511), 1);

    // Reset in the middle of MAC.
    clear_log();
    iv0 = 1'b1;
    step(); e0 = ecnt; log_on = 1'b1;
    iv0 = 1'b0;
    repeat (19) step();
    rst = 1'b0;
    #1;
    check("async_ready", int'(rdy0), 1);
    check("async_addr", int'(a0), 0);
    check("async_acc_en", int'(en0), 0);
    check("async_overrun", int'(or0), 0);
    check("async_newinput", int'(ni0), 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (70) step();
    log_on = 1'b0;
    check("abort_no_valid", cnt(0, 3, 0, 511), 0);
    clear_log();
    iv0 = 1'b1;
    step(); e0 = ecnt; log_on = 1'b1;
    iv0 = 1'b0;
    repeat (75) step();
    log_on = 1'b0;
    check("after_rst_ov_cycle", first_from(0, 3, 0), 68);
    check("after_rst_en_first", first_from(0, 2, 0), 4);

    // input_valid held high for 300 cycles.
    clear_log();
    iv0 = 1'b1;
    step(); e0 = ecnt; log_on = 1'b1;
    repeat (299) step();
    iv0 = 1'b0;
    repeat (80) step();
    log_on = 1'b0;
    check("cont_ni_count", cnt(0, 0, 1, 300), 5);
    check("cont_spacing", first_from(0, 0, 2) - first_from(0, 0, 0), 69);
    check("cont_ov_count", cnt(0, 3, 1, 300), 4);
    check("cont_ov_total", cnt(0, 3, 1, 380), 5);
    check("cont_ov_second", first_from(0, 3, 69), 137);
    check("cont_overrun", lg[0][4][300], 1);
    check("cont_en_count", cnt(0, 2, 1, 380), 320);

    // Impulse through the datapath.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    dp_on = 1'b1;
    din = 16'h0001;
    iv0 = 1'b1;
    step();
    din = 16'h0000;
    repeat (66 * 69) step();
    iv0 = 1'b0;
    repeat (75) step();
    dp_on = 1'b0;
    check("e2e_outputs", out_idx, 67);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
